// File: rtl/blitter_pkg.sv
// Shared types and defaults for the sprite blitter: FSM encoding, screen size,
// colour key and counter-width helper.
package blitter_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  localparam int          SCREEN_W_DEF   = 160;
  localparam int          SCREEN_H_DEF   = 120;
  localparam logic [11:0] KEY_COLOUR_DEF = 12'h0AE;

  // Counter width for 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/blit_pipe.sv
// Delay line that carries {valid, in_bounds, x, y} alongside a ROM read so the
// pixel coordinates come out on the same cycle as the ROM data.
module blit_pipe #(
  parameter int LAT = 1,
  parameter int X_W = 8,
  parameter int Y_W = 8
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_vld,
  input  logic           i_inb,
  input  logic [X_W-1:0] i_x,
  input  logic [Y_W-1:0] i_y,
  output logic           o_vld,
  output logic           o_inb,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y
);

  logic [LAT:1]          r_vld_pipe;
  logic [LAT:1]          r_inb_pipe;
  logic [LAT:1][X_W-1:0] r_x_pipe;
  logic [LAT:1][Y_W-1:0] r_y_pipe;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld_pipe <= '0;
      r_inb_pipe <= '0;
      r_x_pipe   <= '0;
      r_y_pipe   <= '0;
    end else begin
      r_vld_pipe[1] <= i_vld;
      r_inb_pipe[1] <= i_inb;
      r_x_pipe[1]   <= i_x;
      r_y_pipe[1]   <= i_y;
      for (int i = 2; i <= LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_inb_pipe[i] <= r_inb_pipe[i-1];
        r_x_pipe[i]   <= r_x_pipe[i-1];
        r_y_pipe[i]   <= r_y_pipe[i-1];
      end
    end
  end

  assign o_vld = r_vld_pipe[LAT];
  assign o_inb = r_inb_pipe[LAT];
  assign o_x   = r_x_pipe[LAT];
  assign o_y   = r_y_pipe[LAT];

endmodule

// File: rtl/sprite_blitter.sv
// Walks a SPR_W x SPR_H sprite in ROM and streams x/y/colour/plot to the VGA adapter.
// Define BLITTER_TRANSPARENCY_EN to suppress plotting of KEY_COLOUR pixels.
module sprite_blitter
  import blitter_pkg::*;
#(
  parameter int SPR_W    = 16,
  parameter int SPR_H    = 16,
  parameter int X_W      = 8,
  parameter int Y_W      = 8,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int COLOUR_W = 12,
  parameter int ADDR_W   = 15,
  parameter int ROM_LAT  = 1
`ifdef BLITTER_TRANSPARENCY_EN
  , parameter logic [COLOUR_W-1:0] KEY_COLOUR = COLOUR_W'(KEY_COLOUR_DEF)
`endif
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                start,
  input  logic [X_W-1:0]      pos_x,
  input  logic [Y_W-1:0]      pos_y,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                flip_h,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int CW = cnt_w(SPR_W);
  localparam int RW = cnt_w(SPR_H);
  localparam int DW = cnt_w(ROM_LAT);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(SPR_W - 1);

  state_t            r_state, w_state_nxt;
  logic [X_W-1:0]    r_pos_x;
  logic [Y_W-1:0]    r_pos_y;
  logic [ADDR_W-1:0] r_base;
  logic              r_flip;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [DW-1:0]     r_drain;

  logic              w_last_col, w_last_row;
  logic [ADDR_W-1:0] w_col_off;
  logic [X_W:0]      w_x_full;
  logic [Y_W:0]      w_y_full;
  logic              w_inb;
  logic              w_vld, w_vld_inb, w_key_hit;

  assign w_last_col = (r_col == CW'(SPR_W - 1));
  assign w_last_row = (r_row == RW'(SPR_H - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)                      w_state_nxt = S_SCAN;
      S_SCAN:  if (w_last_col && w_last_row)   w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_drain == DW'(ROM_LAT-1))  w_state_nxt = S_DONE;
      default:                                 w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_pos_x <= '0;
      r_pos_y <= '0;
      r_base  <= '0;
      r_flip  <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
      r_drain <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_pos_x <= pos_x;
      r_pos_y <= pos_y;
      r_base  <= base_addr;
      r_flip  <= flip_h;
      r_col   <= '0;
      r_row   <= '0;
      r_drain <= '0;
    end else if (r_state == S_SCAN) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end else if (r_state == S_DRAIN) begin
      r_drain <= r_drain + DW'(1);
    end
  end

  // Flip mirrors only the ROM column; screen x always runs left to right.
  assign w_col_off = r_flip ? (LAST_COL - ADDR_W'(r_col)) : ADDR_W'(r_col);
  assign rom_addr  = (r_state == S_SCAN)
                   ? (r_base + ADDR_W'(r_row) * ADDR_W'(SPR_W) + w_col_off) : '0;

  // One extra bit catches wrap past the coordinate range before the screen test.
  assign w_x_full = {1'b0, r_pos_x} + (X_W+1)'(r_col);
  assign w_y_full = {1'b0, r_pos_y} + (Y_W+1)'(r_row);
  assign w_inb    = !w_x_full[X_W] && (w_x_full < (X_W+1)'(SCREEN_W)) &&
                    !w_y_full[Y_W] && (w_y_full < (Y_W+1)'(SCREEN_H));

  blit_pipe #(.LAT(ROM_LAT), .X_W(X_W), .Y_W(Y_W)) u_pipe (
    .i_clk   (CLOCK_50),
    .i_reset (reset),
    .i_vld   (r_state == S_SCAN),
    .i_inb   (w_inb),
    .i_x     (w_x_full[X_W-1:0]),
    .i_y     (w_y_full[Y_W-1:0]),
    .o_vld   (w_vld),
    .o_inb   (w_vld_inb),
    .o_x     (x),
    .o_y     (y)
  );

`ifdef BLITTER_TRANSPARENCY_EN
  assign w_key_hit = (rom_q == KEY_COLOUR);
`else
  assign w_key_hit = 1'b0;
`endif

  assign plot   = w_vld && w_vld_inb && !w_key_hit;
  assign colour = w_vld ? rom_q : '0;
  assign busy   = (r_state == S_SCAN) || (r_state == S_DRAIN);
  assign done   = (r_state == S_DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: a 4x4/ROM_LAT=1 instance driven from a vector table
// with a pixel scoreboard, plus a 2x2/ROM_LAT=2 instance for address wrap.
module tb_sprite_blitter;

`ifdef BLITTER_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
  localparam int KEY_PLOTS = 15;
`else
  localparam bit TRANSP = 1'b0;
  localparam int KEY_PLOTS = 16;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, flip_h, plot, busy, done;
  logic [7:0]  pos_x, pos_y, x, y;
  logic [14:0] base_addr, rom_addr;
  logic [11:0] rom_q, colour;

  logic        d2_start, d2_flip, d2_plot, d2_busy, d2_done;
  logic [7:0]  d2_px, d2_py, d2_x, d2_y;
  logic [14:0] d2_base, d2_addr;
  logic [11:0] d2_q1, d2_rom_q, d2_colour;

  sprite_blitter #(.SPR_W(4), .SPR_H(4), .ROM_LAT(1)) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .pos_x(pos_x), .pos_y(pos_y),
    .base_addr(base_addr), .flip_h(flip_h), .rom_addr(rom_addr), .rom_q(rom_q),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done));

  sprite_blitter #(.SPR_W(2), .SPR_H(2), .ROM_LAT(2)) dut2 (
    .CLOCK_50(clk), .reset(reset), .start(d2_start), .pos_x(d2_px), .pos_y(d2_py),
    .base_addr(d2_base), .flip_h(d2_flip), .rom_addr(d2_addr), .rom_q(d2_rom_q),
    .x(d2_x), .y(d2_y), .colour(d2_colour), .plot(d2_plot), .busy(d2_busy), .done(d2_done));

  // ROM images: data = address, optionally word 5 replaced by the colour key.
  bit key5 = 1'b0;
  function automatic logic [11:0] romf(input logic [14:0] a);
    if (key5 && a == 15'd5) return 12'h0AE;
    return a[11:0];
  endfunction
  always @(posedge clk) rom_q <= romf(rom_addr);
  always @(posedge clk) begin
    d2_q1    <= d2_addr[11:0];
    d2_rom_q <= d2_q1;
  end

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {int cyc; int px; int py; int col;} pix_t;
  pix_t sb[$];

  typedef struct {
    int px; int py; int base; bit flip; bit key5;
    int rep_at; int rst_at; int exp_plots; int exp_busy; int exp_done;
  } vec_t;
  vec_t vt[8];

  task automatic run(input int id, input vec_t v);
    int n_plot = 0, n_busy = 0, n_done = 0, d_cyc = 0;
    pix_t e;
    key5 = v.key5;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        int a, col, xx, yy, cy;
        a   = (v.base + r*4 + (v.flip ? 3-c : c)) % 32768;
        col = (v.key5 && a == 5) ? 'h0AE : (a & 'hFFF);
        xx  = v.px + c;
        yy  = v.py + r;
        cy  = r*4 + c + 2;
        if (xx < 160 && yy < 120 && !(TRANSP && col == 'h0AE) &&
            (v.rst_at == 0 || cy <= v.rst_at))
          sb.push_back('{cy, xx, yy, col});
      end
    @(negedge clk);
    pos_x = 8'(v.px); pos_y = 8'(v.py); base_addr = 15'(v.base); flip_h = v.flip;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (plot) begin
        n_plot++;
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL v%0d unexpected_plot: cycle %0d x=%0d y=%0d, none required", id, k, x, y);
        end else begin
          e = sb.pop_front();
          chk($sformatf("v%0d plot_cycle", id), k, e.cyc);
          chk($sformatf("v%0d x", id), {24'd0, x}, e.px);
          chk($sformatf("v%0d y", id), {24'd0, y}, e.py);
          chk($sformatf("v%0d colour", id), {20'd0, colour}, e.col);
        end
      end
      if (busy) n_busy++;
      if (done) begin n_done++; d_cyc = k; end
      if (k == v.rep_at) begin start = 1'b1; pos_x = 8'd0; flip_h = ~flip_h; end
      if (k == v.rep_at + 1) start = 1'b0;
      if (k == v.rst_at) reset = 1'b1;
      if (k == v.rst_at + 1) reset = 1'b0;
    end
    chk($sformatf("v%0d plot_count", id), n_plot, v.exp_plots);
    chk($sformatf("v%0d busy_len", id), n_busy, v.exp_busy);
    chk($sformatf("v%0d done_count", id), n_done, (v.exp_done != 0) ? 1 : 0);
    if (v.exp_done != 0) chk($sformatf("v%0d done_cycle", id), d_cyc, v.exp_done);
    chk($sformatf("v%0d missing_plots", id), sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int ea[4];
    // px, py, base, flip, key5, rep_at, rst_at, plots, busy, done
    vt[0] = '{10, 20, 0, 1'b0, 1'b0, 0, 0, 16, 17, 18};
    vt[1] = '{10, 20, 0, 1'b1, 1'b0, 0, 0, 16, 17, 18};
    vt[2] = '{158, 118, 0, 1'b0, 1'b0, 0, 0, 4, 17, 18};
    vt[3] = '{10, 20, 0, 1'b0, 1'b1, 0, 0, KEY_PLOTS, 17, 18};
    vt[4] = '{254, 10, 0, 1'b0, 1'b0, 0, 0, 0, 17, 18};
    vt[5] = '{10, 20, 100, 1'b0, 1'b0, 3, 0, 16, 17, 18};
    vt[6] = '{10, 20, 0, 1'b0, 1'b0, 0, 7, 6, 7, 0};
    vt[7] = '{30, 40, 32760, 1'b1, 1'b0, 0, 0, 16, 17, 18};

    // Reset with a simultaneous start: outputs zero and the start is dropped.
    reset = 1'b1; start = 1'b1; pos_x = 8'd3; pos_y = 8'd4; base_addr = 15'd9; flip_h = 1'b0;
    d2_start = 1'b0; d2_px = '0; d2_py = '0; d2_base = '0; d2_flip = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst rom_addr", {17'd0, rom_addr}, 0);
    chk("rst xy", {16'd0, x, y}, 0);
    chk("rst colour", {20'd0, colour}, 0);
    chk("rst plot_busy_done", {29'd0, plot, busy, done}, 0);
    chk("rst dut2 plot_busy_done", {29'd0, d2_plot, d2_busy, d2_done}, 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("start_in_reset_dropped busy", {31'd0, busy}, 0);

    foreach (vt[i]) run(i, vt[i]);

    // ROM_LAT=2, 2x2 sprite whose addresses wrap past 2^15.
    ea = '{32766, 32767, 0, 1};
    @(negedge clk);
    d2_px = 8'd5; d2_py = 8'd5; d2_base = 15'd32766; d2_flip = 1'b0; d2_start = 1'b1;
    @(posedge clk);
    #1 d2_start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k <= 4) chk($sformatf("lat2 rom_addr c%0d", k), {17'd0, d2_addr}, ea[k-1]);
      chk($sformatf("lat2 plot c%0d", k), {31'd0, d2_plot}, (k >= 3 && k <= 6) ? 1 : 0);
      if (k >= 3 && k <= 6) begin
        chk($sformatf("lat2 colour c%0d", k), {20'd0, d2_colour}, ea[k-3] & 'hFFF);
        chk($sformatf("lat2 xy c%0d", k), {16'd0, d2_x, d2_y},
            ((5 + (k-3)%2) << 8) | (5 + (k-3)/2));
      end
      chk($sformatf("lat2 busy c%0d", k), {31'd0, d2_busy}, (k <= 6) ? 1 : 0);
      chk($sformatf("lat2 done c%0d", k), {31'd0, d2_done}, (k == 7) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
